// File: rtl/io_mem_bank_pkg.sv
// ==========================================================================
// io_mem_bank_pkg : register map, status bit positions and byte-merge helper
// rev 1.0
// ==========================================================================
`default_nettype none

package io_mem_bank_pkg;

   localparam logic [10:0] IO_KEY_STAT = 11'd0;
   localparam logic [10:0] IO_KEY_DATA = 11'd1;
   localparam logic [10:0] IO_MS_COUNT = 11'd2;
   localparam logic [10:0] IO_MS_CMP   = 11'd3;
   localparam logic [10:0] IO_TMR_STAT = 11'd4;
   localparam logic [10:0] IO_LEDS     = 11'd5;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_CNT_LSB   = 8;
   localparam int TMR_MATCH      = 0;

   localparam logic [31:0] MS_CMP_RST = 32'hFFFF_FFFF;

   // Replace only the byte lanes whose enable is set.
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] wr_val,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wr_val[8*i +: 8];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_key_fifo.sv
// ==========================================================================
// io_key_fifo : keypad scan-code FIFO with wrapping pointers and count
// rev 1.0
// ==========================================================================
`default_nettype none

module io_key_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [7:0]                 din,
   input  logic                       pop,
   output logic [7:0]                 dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf_set
);
   import io_mem_bank_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_eff, pop_eff;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign dout  = empty ? 8'd0 : mem_q[rd_ptr_q];

   always_comb begin
      pop_eff  = pop && !empty;
      // A same-cycle pop frees a slot, so a push into a full FIFO is kept.
      push_eff = push && (!full || pop_eff);
      ovf_set  = push && full && !pop_eff;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_eff) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_eff, pop_eff})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/io_mem_bank.sv
// ==========================================================================
// io_mem_bank : memory-mapped keypad FIFO, ms timer with compare, LED register
// rev 1.0
// ==========================================================================
`default_nettype none

module io_mem_bank
   import io_mem_bank_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  memWrite,
   input  logic [10:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic [7:0]  leds
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   ms_q, ms_d;
   logic [31:0]   cmp_q, cmp_d;
   logic          match_q, match_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    leds_q, leds_d;

   logic          rd_acc, wr_acc, pop, tick, ms_upd;
   logic [7:0]    key_dout;
   logic [CW-1:0] key_count;
   logic          key_full, key_empty, key_ovf_set;
   logic [31:0]   key_stat;

   io_key_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (key_valid),
      .din     (key_code),
      .pop     (pop),
      .dout    (key_dout),
      .count   (key_count),
      .full    (key_full),
      .empty   (key_empty),
      .ovf_set (key_ovf_set)
   );

   assign rd_acc = en && (memWrite == 4'b0000);
   assign wr_acc = en && (memWrite != 4'b0000);
   assign pop    = rd_acc && (addr == IO_KEY_DATA);
   assign tick   = (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      key_stat = 32'd0;
      key_stat[STAT_NOT_EMPTY]           = !key_empty;
      key_stat[STAT_FULL]                = key_full;
      key_stat[STAT_OVF]                 = ovf_q;
      key_stat[STAT_CNT_LSB +: 8]        = 8'(key_count);
   end

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);

      // A CPU write wins over the tick increment in the same cycle.
      ms_d   = ms_q;
      ms_upd = 1'b0;
      if (wr_acc && addr == IO_MS_COUNT) begin
         ms_d   = be_merge(ms_q, wdata, memWrite);
         ms_upd = 1'b1;
      end else if (tick) begin
         ms_d   = ms_q + 32'd1;
         ms_upd = 1'b1;
      end

      cmp_d = cmp_q;
      if (wr_acc && addr == IO_MS_CMP) cmp_d = be_merge(cmp_q, wdata, memWrite);

      match_d = match_q;
      if (wr_acc && addr == IO_TMR_STAT && memWrite[0] && wdata[TMR_MATCH]) match_d = 1'b0;
      if (ms_upd && ms_d == cmp_q) match_d = 1'b1;

      ovf_d = ovf_q;
      if (wr_acc && addr == IO_KEY_STAT && memWrite[0] && wdata[STAT_OVF]) ovf_d = 1'b0;
      if (key_ovf_set) ovf_d = 1'b1;

      leds_d = leds_q;
      if (wr_acc && addr == IO_LEDS && memWrite[0]) leds_d = wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         ms_q    <= 32'd0;
         cmp_q   <= MS_CMP_RST;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         leds_q  <= 8'd0;
      end else begin
         presc_q <= presc_d;
         ms_q    <= ms_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
         leds_q  <= leds_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (en) begin
         unique case (addr)
            IO_KEY_STAT: rdata = key_stat;
            IO_KEY_DATA: rdata = {24'd0, key_dout};
            IO_MS_COUNT: rdata = ms_q;
            IO_MS_CMP:   rdata = cmp_q;
            IO_TMR_STAT: rdata = {31'd0, match_q};
            IO_LEDS:     rdata = {24'd0, leds_q};
            default:     rdata = 32'd0;
         endcase
      end
   end

   assign leds = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_io_mem_bank.sv
// ==========================================================================
// tb_io_mem_bank : vector table plus hand sequences, rdata scoreboard
// rev 1.0
// ==========================================================================
`default_nettype none

module tb_io_mem_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  memWrite = 4'd0;
   logic [10:0] addr = 11'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'd0;
   logic [7:0]  leds;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [10:0] addr;
      logic [31:0] wd;
      logic        kv;
      logic [7:0]  kc;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] exp_q[$];
   string       nm_q[$];

   io_mem_bank #(.TICK_DIV(4), .FIFO_DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .memWrite  (memWrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .key_valid (key_valid),
      .key_code  (key_code),
      .leds      (leds)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic e, input logic [3:0] we, input logic [10:0] a,
                               input logic [31:0] wd, input logic kv, input logic [7:0] kc,
                               input logic chk, input logic [31:0] ex, input string nm);
      vec_t v;
      v.en = e; v.we = we; v.addr = a; v.wd = wd; v.kv = kv; v.kc = kc;
      v.chk = chk; v.exp = ex; v.name = nm;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, ex);
      end
   endtask

   // One bus cycle: drive, compare rdata mid-cycle, then cross the edge.
   task automatic drive(input vec_t v);
      logic [31:0] ex;
      string       nm;
      en = v.en; memWrite = v.we; addr = v.addr; wdata = v.wd;
      key_valid = v.kv; key_code = v.kc;
      if (v.chk) begin
         exp_q.push_back(v.exp);
         nm_q.push_back(v.name);
      end
      @(negedge clk);
      if (v.chk) begin
         ex = exp_q.pop_front();
         nm = nm_q.pop_front();
         check(nm, rdata, ex);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [10:0] a, input logic [31:0] ex, input string nm);
      drive(mk(1'b1, 4'd0, a, 32'd0, 1'b0, 8'd0, 1'b1, ex, nm));
   endtask

   task automatic wr(input logic [10:0] a, input logic [3:0] we, input logic [31:0] wd);
      drive(mk(1'b1, we, a, wd, 1'b0, 8'd0, 1'b0, 32'd0, ""));
   endtask

   task automatic idle();
      drive(mk(1'b0, 4'd0, 11'd0, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, ""));
   endtask

   task automatic push_key(input logic [7:0] kc);
      drive(mk(1'b0, 4'd0, 11'd0, 32'd0, 1'b1, kc, 1'b0, 32'd0, ""));
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; memWrite = 4'd0; key_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // Reset state, basic FIFO traffic, empty pops, LED byte enables.
      tbl.push_back(mk(1, 4'h0, 11'd0, 0, 0, 8'h00, 1, 32'h0000_0000, "rst_key_stat"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 0, 8'h00, 1, 32'h0000_0000, "rst_key_data"));
      tbl.push_back(mk(1, 4'h0, 11'd2, 0, 0, 8'h00, 1, 32'h0000_0000, "rst_ms_count"));
      tbl.push_back(mk(1, 4'h0, 11'd3, 0, 0, 8'h00, 1, 32'hFFFF_FFFF, "rst_ms_cmp"));
      tbl.push_back(mk(1, 4'h0, 11'd4, 0, 0, 8'h00, 1, 32'h0000_0000, "rst_tmr_stat"));
      tbl.push_back(mk(1, 4'h0, 11'd5, 0, 0, 8'h00, 1, 32'h0000_0000, "rst_leds"));
      tbl.push_back(mk(0, 4'h0, 11'd0, 0, 1, 8'h1C, 1, 32'h0000_0000, "en0_reads_zero"));
      tbl.push_back(mk(0, 4'h0, 11'd0, 0, 1, 8'h32, 0, 32'h0000_0000, ""));
      tbl.push_back(mk(1, 4'h0, 11'd0, 0, 0, 8'h00, 1, 32'h0000_0201, "t1_stat_two"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 0, 8'h00, 1, 32'h0000_001C, "t1_pop_1c"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 0, 8'h00, 1, 32'h0000_0032, "t1_pop_32"));
      tbl.push_back(mk(1, 4'h0, 11'd0, 0, 0, 8'h00, 1, 32'h0000_0000, "t1_stat_empty"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 0, 8'h00, 1, 32'h0000_0000, "pop_on_empty"));
      tbl.push_back(mk(1, 4'h0, 11'd0, 0, 0, 8'h00, 1, 32'h0000_0000, "stat_after_empty_pop"));
      tbl.push_back(mk(1, 4'h1, 11'd5, 32'h1234_56A5, 0, 8'h00, 0, 32'h0, ""));
      tbl.push_back(mk(1, 4'h0, 11'd5, 0, 0, 8'h00, 1, 32'h0000_00A5, "leds_write"));
      tbl.push_back(mk(1, 4'hE, 11'd5, 32'hFFFF_FF00, 0, 8'h00, 0, 32'h0, ""));
      tbl.push_back(mk(1, 4'h0, 11'd5, 0, 0, 8'h00, 1, 32'h0000_00A5, "leds_upper_be_ignored"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 1, 8'h77, 1, 32'h0000_0000, "pushpop_empty"));
      tbl.push_back(mk(1, 4'h0, 11'd0, 0, 0, 8'h00, 1, 32'h0000_0101, "pushpop_empty_stat"));
      tbl.push_back(mk(1, 4'h0, 11'd1, 0, 0, 8'h00, 1, 32'h0000_0077, "pushpop_empty_data"));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
      check("leds_port", {24'd0, leds}, 32'h0000_00A5);

      // Overflow: 17 pushes, set-wins clear, then plain clear.
      do_reset();
      for (int i = 0; i < 17; i++) push_key(8'(i + 1));
      rd(11'd0, 32'h0000_1007, "t2_full_ovf");
      drive(mk(1, 4'h1, 11'd0, 32'h4, 1, 8'h99, 0, 32'h0, ""));
      rd(11'd0, 32'h0000_1007, "ovf_set_wins_clear");
      wr(11'd0, 4'h1, 32'h4);
      rd(11'd0, 32'h0000_1003, "t2_ovf_cleared");

      // Full FIFO with simultaneous pop and push.
      drive(mk(1, 4'h0, 11'd1, 32'h0, 1, 8'hEE, 1, 32'h0000_0001, "t3_full_pushpop_head"));
      rd(11'd0, 32'h0000_1003, "t3_count_kept_no_ovf");
      for (int i = 2; i <= 16; i++) rd(11'd1, 32'(i), "t3_drain");
      rd(11'd1, 32'h0000_00EE, "t3_tail_code");
      rd(11'd0, 32'h0000_0000, "t3_drained");

      // Timer: TICK_DIV=4, compare 3 reached after 12 cycles.
      do_reset();
      wr(11'd3, 4'hF, 32'd3);
      for (int i = 0; i < 10; i++) idle();
      rd(11'd2, 32'd2, "t4_count_before");
      rd(11'd2, 32'd3, "t4_count_three");
      rd(11'd4, 32'd1, "t4_match_set");
      wr(11'd4, 4'h1, 32'd1);
      rd(11'd4, 32'd0, "t4_match_cleared");
      wr(11'd2, 4'hF, 32'd3);
      rd(11'd4, 32'd1, "match_by_write");
      idle();
      wr(11'd2, 4'hF, 32'h100);
      rd(11'd2, 32'h0000_0100, "write_beats_tick");

      // Byte-lane write to MS_COUNT; ignored writes.
      do_reset();
      wr(11'd2, 4'hF, 32'h5);
      wr(11'd2, 4'h2, 32'h0000_AB00);
      drive(mk(0, 4'hF, 11'd2, 32'hFFFF_FFFF, 0, 8'h00, 1, 32'h0, "t5_en0_write_reads_zero"));
      rd(11'd2, 32'h0000_AB05, "t5_byte1_merge");
      wr(11'd9, 4'hF, 32'hFFFF_FFFF);
      rd(11'd9, 32'h0, "t5_addr9_reads_zero");
      rd(11'd5, 32'h0, "t5_addr9_no_effect");
      rd(11'd3, 32'hFFFF_FFFF, "t5_cmp_untouched");

      // Reset in the middle of a KEY_DATA access.
      do_reset();
      push_key(8'h11); push_key(8'h22); push_key(8'h33);
      wr(11'd5, 4'h1, 32'h5A);
      check("t6_leds_before", {24'd0, leds}, 32'h0000_005A);
      rd(11'd0, 32'h0000_0301, "t6_three_entries");
      en = 1'b1; memWrite = 4'd0; addr = 11'd1; reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; en = 1'b0;
      check("t6_leds_after", {24'd0, leds}, 32'h0);
      rd(11'd0, 32'h0, "t6_stat_reset");
      rd(11'd1, 32'h0, "t6_data_reset");
      rd(11'd2, 32'h0, "t6_ms_reset");
      rd(11'd3, 32'hFFFF_FFFF, "t6_cmp_reset");
      rd(11'd4, 32'h0, "t6_tmr_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
